// File: rtl/mux_arbiter_rr.sv
// mux_arbiter_rr
//   Round-robin arbiter that shares one N:1 mux output channel between N
//   requesters. One winner at a time is registered onto a valid/ready output
//   channel; the winner gets a one-cycle ack when the word is accepted.
//
// Parameters
//   N     number of requesters (2..16)
//   W     data width per requester
//   SELW  select width, $clog2(N)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        per-requester request, bit i pairs with data[i*W +: W]
//   data       flattened request words
//   lock       per-requester burst lock (only with MUX_ARB_LOCK_EN)
//   ack        one-hot acceptance pulse, grant & {out_valid & out_ready}
//   grant      registered one-hot current winner
//   sel        registered binary index of the winner (shared mux select)
//   out_valid  registered, out_data holds a valid word
//   out_data   registered snapshot of data[sel] taken at grant time
//   out_ready  downstream accepts the word when out_valid & out_ready
//
// Build option
//   MUX_ARB_LOCK_EN  adds the lock port: a locked winner keeps the channel
//                    on its next request instead of passing it on.
//
// state | meaning
// IDLE  | out_valid low; pick a winner from req, register it, go BUSY
// BUSY  | word presented; hold until out_ready, then ack and return to IDLE

module mux_arbiter_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SELW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  data,
`ifdef MUX_ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    ack,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] sel,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  input  logic            out_ready
);

  localparam int SW1 = SELW + 1;
  localparam logic [SELW:0]   N_EXT    = SW1'(N);
  localparam logic [SELW-1:0] LAST_RST = SELW'(N - 1);
  localparam logic [N-1:0]    ONE_N    = N'(1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [N-1:0]    grant_nxt;
  logic [SELW-1:0] sel_nxt;
  logic            valid_nxt;
  logic [W-1:0]    data_nxt;
  logic [SELW-1:0] last, last_nxt;

  logic            pick_found;
  logic [SELW-1:0] pick_idx;
  logic [SELW:0]   cand;
  logic            win_valid;
  logic [SELW-1:0] win_idx;

`ifdef MUX_ARB_LOCK_EN
  logic locked, locked_nxt;
  logic lock_hold;
`endif

  // Search last+1, last+2, ... with an explicit wrap at N so non-power-of-two
  // N never visits an index beyond N-1.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= N; off++) begin
      cand = {1'b0, last} + SW1'(off);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!pick_found && req[cand[SELW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[SELW-1:0];
      end
    end
  end

  // sel still holds the previous winner while IDLE, so a locked requester is
  // recognised by looking at req[sel].
`ifdef MUX_ARB_LOCK_EN
  always_comb begin
    lock_hold = locked & req[sel];
    win_valid = lock_hold | pick_found;
    win_idx   = lock_hold ? sel : pick_idx;
  end
`else
  always_comb begin
    win_valid = pick_found;
    win_idx   = pick_idx;
  end
`endif

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    valid_nxt = out_valid;
    data_nxt  = out_data;
    last_nxt  = last;
`ifdef MUX_ARB_LOCK_EN
    locked_nxt = locked;
`endif
    case (state)
      IDLE: begin
`ifdef MUX_ARB_LOCK_EN
        // Survives only a grant made through the lock; any round-robin grant
        // or a dropped req[sel] releases it.
        locked_nxt = lock_hold;
`endif
        if (win_valid) begin
          state_nxt = BUSY;
          grant_nxt = ONE_N << win_idx;
          sel_nxt   = win_idx;
          valid_nxt = 1'b1;
          data_nxt  = data[int'(win_idx)*W +: W];
        end
      end
      BUSY: begin
        if (out_ready) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          valid_nxt = 1'b0;
`ifdef MUX_ARB_LOCK_EN
          if (lock[sel]) begin
            locked_nxt = 1'b1;
          end else begin
            locked_nxt = 1'b0;
            last_nxt   = sel;
          end
`else
          last_nxt = sel;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      sel       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      last      <= LAST_RST;
    end else begin
      state     <= state_nxt;
      grant     <= grant_nxt;
      sel       <= sel_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      last      <= last_nxt;
    end
  end

`ifdef MUX_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) locked <= 1'b0;
    else        locked <= locked_nxt;
  end
`endif

  assign ack = grant & {N{out_valid & out_ready}};

endmodule

// File: tb/tb_mux_arbiter_rr.sv
module tb_mux_arbiter_rr;

  localparam int N = 4;
  localparam int W = 8;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  data;
`ifdef MUX_ARB_LOCK_EN
  logic [N-1:0]    lock;
`endif
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic [SELW-1:0] sel;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_ready;

  int n_pass  = 0;
  int n_total = 0;

  // transaction-level reference: is a word outstanding, whose, what, last winner
  bit        m_busy;
  int        m_sel;
  logic [W-1:0] m_data;
  int        m_last;

  mux_arbiter_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .data      (data),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .grant     (grant),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input int last_i, input logic [N-1:0] r);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last_i + k) % N;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [N+SELW+W:0] model_vec();
    logic [N-1:0] g;
    g = m_busy ? (N'(1) << m_sel) : '0;
    return {g, SELW'(m_sel), m_busy, m_data};
  endfunction

  // advance the reference across the coming edge, then step past it
  task automatic tick();
    int w;
    if (m_busy) begin
      if (out_ready) begin
        m_busy = 1'b0;
        m_last = m_sel;
      end
    end else begin
      w = rr_pick(m_last, req);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_sel  = w;
        m_data = data[w*W +: W];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    data = '0;
    out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    m_busy = 1'b0;
    m_sel  = 0;
    m_data = '0;
    m_last = N - 1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    data = '0;
    out_ready = 1'b1;
`ifdef MUX_ARB_LOCK_EN
    lock = '0;
`endif
    #2;
    n_total++;
    if ({grant, sel, out_valid, out_data, ack} !== '0) begin
      $display("FAIL reset_assert: got %h expected 0", {grant, sel, out_valid, out_data, ack});
    end else n_pass++;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++;
      if ({grant, sel, out_valid, out_data, ack} !== '0) begin
        $display("FAIL reset_idle[%0d]: got %h expected 0", c, {grant, sel, out_valid, out_data, ack});
      end else n_pass++;
    end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1;
    req = 4'b0100;
    data[2*W +: W] = 8'hA5;
    tick();
    n_total++;
    if ({grant, sel, out_valid, out_data} !== {4'b0100, 2'd2, 1'b1, 8'hA5}) begin
      $display("FAIL single_grant: got %h expected %h", {grant, sel, out_valid, out_data}, {4'b0100, 2'd2, 1'b1, 8'hA5});
    end else n_pass++;
    n_total++;
    if (ack !== 4'b0100) $display("FAIL single_ack: got %b expected 0100", ack);
    else n_pass++;
    tick();
    n_total++;
    if ({out_valid, ack} !== 5'b0) $display("FAIL single_gap: got %b expected 00000", {out_valid, ack});
    else n_pass++;
    for (int b = 0; b < 3; b++) begin
      tick();
      n_total++;
      if ({grant, ack, out_valid} !== {4'b0100, 4'b0100, 1'b1}) begin
        $display("FAIL single_repeat[%0d]: got %h expected %h", b, {grant, ack, out_valid}, {4'b0100, 4'b0100, 1'b1});
      end else n_pass++;
      tick();
    end
    req = '0;
  endtask

  task automatic test_rotation();
    int order[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    out_ready = 1'b1;
    req = 4'b1111;
    data = 32'h44_33_22_11;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) order.push_back(int'(sel));
      n_total++;
      if ({grant, sel, out_valid, out_data} !== model_vec()) begin
        $display("FAIL rotation_cycle[%0d]: got %h expected %h", c, {grant, sel, out_valid, out_data}, model_vec());
      end else n_pass++;
    end
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (order.size() <= i) $display("FAIL rotation_order[%0d]: got none expected %0d", i, exp_order[i]);
      else if (order[i] != exp_order[i]) $display("FAIL rotation_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    req = 4'b0010;
    data[1*W +: W] = 8'h3C;
    tick();
    for (int c = 0; c < 5; c++) begin
      data[1*W +: W] = 8'($urandom);
      n_total++;
      if ({grant, sel, out_valid, out_data, ack} !== {4'b0010, 2'd1, 1'b1, 8'h3C, 4'b0000}) begin
        $display("FAIL backpressure_hold[%0d]: got %h expected %h", c, {grant, sel, out_valid, out_data, ack}, {4'b0010, 2'd1, 1'b1, 8'h3C, 4'b0000});
      end else n_pass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (ack !== 4'b0010) $display("FAIL backpressure_ack: got %b expected 0010", ack);
    else n_pass++;
    req = '0;
    tick();
    n_total++;
    if ({out_valid, grant, ack} !== 9'b0) $display("FAIL backpressure_release: got %b expected 0", {out_valid, grant, ack});
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    req = 4'b1000;
    data[3*W +: W] = 8'h33;
    tick();
    n_total++;
    if ({sel, out_valid, out_data} !== {2'd3, 1'b1, 8'h33}) begin
      $display("FAIL wrap_first: got %h expected %h", {sel, out_valid, out_data}, {2'd3, 1'b1, 8'h33});
    end else n_pass++;
    req = 4'b1001;
    data[0*W +: W] = 8'h11;
    data[3*W +: W] = 8'h34;
    tick();
    tick();
    n_total++;
    if ({sel, out_valid, out_data} !== {2'd0, 1'b1, 8'h11}) begin
      $display("FAIL wrap_second: got %h expected %h", {sel, out_valid, out_data}, {2'd0, 1'b1, 8'h11});
    end else n_pass++;
    tick();
    tick();
    n_total++;
    if ({sel, out_valid, out_data} !== {2'd3, 1'b1, 8'h34}) begin
      $display("FAIL wrap_third: got %h expected %h", {sel, out_valid, out_data}, {2'd3, 1'b1, 8'h34});
    end else n_pass++;
    req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    req = 4'b0001;
    data[0*W +: W] = 8'h5A;
    tick();
    out_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({grant, out_valid, sel, out_data} !== '0) begin
      $display("FAIL mid_reset_clear: got %h expected 0", {grant, out_valid, sel, out_data});
    end else n_pass++;
    n_total++;
    if (ack !== 4'b0000) $display("FAIL mid_reset_ack: got %b expected 0000", ack);
    else n_pass++;
    do_reset();
  endtask

  task automatic test_random();
    logic [N-1:0] exp_ack;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_ack = (m_busy && out_ready) ? (N'(1) << m_sel) : '0;
      n_total++;
      if (ack !== exp_ack) $display("FAIL random_ack[%0d]: got %b expected %b", c, ack, exp_ack);
      else n_pass++;
      for (int i = 0; i < N; i++) begin
        if (!req[i] || exp_ack[i]) begin
          req[i] = ($urandom_range(0, 2) != 0);
          data[i*W +: W] = 8'($urandom);
        end
      end
      tick();
      n_total++;
      if ({grant, sel, out_valid, out_data} !== model_vec()) begin
        $display("FAIL random_state[%0d]: got %h expected %h", c, {grant, sel, out_valid, out_data}, model_vec());
      end else n_pass++;
    end
    req = '0;
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    int order[$];
    int exp_order[5] = '{0, 0, 0, 1, 0};
    do_reset();
    out_ready = 1'b1;
    req = 4'b0011;
    lock = 4'b0001;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) begin
        order.push_back(int'(sel));
        if (order.size() == 3) lock = 4'b0000;
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (order.size() <= i) $display("FAIL lock_order[%0d]: got none expected %0d", i, exp_order[i]);
      else if (order[i] != exp_order[i]) $display("FAIL lock_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]);
      else n_pass++;
    end
    req = '0;
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_mid_reset();
    test_random();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_arbiter_rr.md
# mux_arbiter_rr

Round-robin arbiter and sequencer that shares a single N:1 multiplexer output channel between N requesters. Each requester presents a request and a data word. The block picks one winner, drives the mux select, and registers the selected word onto a valid/ready output channel. It returns a one-cycle acknowledge to the winner when the word is accepted downstream.

## Interface
- `N`, default 4: number of requesters, range 2..16.
- `W`, default 8: data width per requester.
- `SELW` (localparam) = $clog2(N): select width.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `req`  in  N  per-requester request; bit i pairs with `data[i*W +: W]`.
- `data`  in  N*W  flattened request words.
- `lock`  in  N  per-requester burst lock; present only when `MUX_ARB_LOCK_EN` is defined.
- `ack`  out  N  one-hot acceptance pulse, combinational: `ack[i] = grant[i] & out_valid & out_ready`.
- `grant`  out  N  registered one-hot current winner.
- `sel`  out  SELW  registered binary index of the winner; drives the shared mux.
- `out_valid`  out  1  registered; the word on `out_data` is valid.
- `out_data`  out  W  registered copy of `data[sel]`, captured at grant time.
- `out_ready`  in  1  downstream accepts the word when `out_valid & out_ready`.

## Operation
- FSM states:
  - IDLE: `out_valid`=0. If `|req`, select the winner, register `grant`, `sel`, `out_data` and `out_valid`=1, then go to BUSY. Otherwise stay in IDLE.
  - BUSY: hold `grant`, `sel` and `out_data` stable while `out_ready`=0. On `out_valid & out_ready`: pulse `ack[sel]`, update `last` to `sel`, clear `out_valid` and `grant`, then go to IDLE.
- Round-robin pointer `last` (SELW bits) holds the most recent winner.
  - Search order is `last+1, last+2, …` wrapping modulo N; the first index with `req` high wins.
  - Wrap rule: index N-1 is followed by index 0, including for non-power-of-two N.
- Requester contract:
  - Hold `req` and `data` stable until its `ack`.
  - On `ack`, either deassert `req` or present the next word at the same edge.
  - A `req` that drops before `ack` is a protocol violation and is not checked.
- `out_data` is a snapshot. Changes on `data` during BUSY do not affect it.
- Every accepted beat is followed by one IDLE cycle. Peak throughput is 1 beat per 2 cycles, so a stale `req` from the winner is never re-sampled.
- Requests arriving during BUSY wait. They are evaluated in the next IDLE cycle.
- Reset values:
  - `grant`=0, `sel`=0, `out_valid`=0, `out_data`=0.
  - `last`=N-1, so requester 0 has first priority.
  - State = IDLE.
- Reset asserted mid-transfer: all outputs clear immediately (asynchronous), the in-flight beat is dropped, and no `ack` is produced.

## Timing
- Grant latency: `req` high in IDLE at edge k gives `grant`, `sel`, `out_valid` high after edge k.
- `ack` is asserted in the same cycle as the downstream handshake. The requester samples it at the next edge.
- Minimum request-to-ack time is 1 cycle after grant, with `out_ready` tied high.
- No combinational path from `req` or `data` to any output. The only combinational output path is `out_ready` to `ack`.
- Reset deassertion is expected to be synchronised externally. The first active edge after `rst_n` rises may grant.

## Configuration
- `MUX_ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - If `lock[sel]`=1 at acceptance, `last` is not advanced and a `locked` flag is set.
  - In the next IDLE cycle, if `locked` and `req[sel]`=1, the same requester wins regardless of round-robin order.
  - `locked` clears on any grant made without the lock, or when `req[sel]`=0 in IDLE.
  - `locked` resets to 0.
- `MUX_ARB_LOCK_EN` undefined: the `lock` port and `locked` flag are absent, and the pointer always advances on acceptance.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0, then release it with `req`=0.
  - Required response: all outputs 0 and `last`=3 held indefinitely. `rst_n` low mid-BUSY clears `out_valid` and `grant` in the same cycle, with no `ack`.
- Single requester, with `out_ready`=1:
  - Stimulus: `req`=4'b0100, `data[2]`=8'hA5.
  - Required response: the next cycle has `grant`=4'b0100, `sel`=2, `out_data`=8'hA5 and `ack`=4'b0100 for one cycle. Repeated requests are accepted every 2 cycles.
- Fair rotation, from reset with `out_ready`=1:
  - Stimulus: `req`=4'b1111 held.
  - Required response: grant order 0,1,2,3,0.
- Backpressure:
  - Stimulus: `out_ready`=0 for 5 cycles after grant to requester 1, with `data[1]` changing during BUSY.
  - Required response: `out_valid`, `sel`=1 and `out_data` stay stable, `ack`=0 throughout. `ack[1]` pulses in the cycle `out_ready` rises.
- Wrap and sparse requests:
  - Stimulus: `last`=3 with `req`=4'b1000, then `req`=4'b1001 held.
  - Required response: requester 3 is granted first; after it, requester 0 wins, then requester 3.
- Lock (only with `MUX_ARB_LOCK_EN`):
  - Stimulus: `req`=4'b0011, with `lock[0]`=1 for 3 beats and then 0.
  - Required response: grants 0,0,0, then 1, then 0.
